// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM state encodings and command_group field geometry shared by the fetch stage
package instr_fetch_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    localparam int GROUP_W           = 3;
    localparam int DEFAULT_GROUP_MSB = 15;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle of the fetch stage's external buses
//   imem_*     : req/gnt + rvalid read port to instruction memory
//   instr_*    : valid/ready instruction stream to decode/control (+ command_group)
//   redirect_* : one-cycle taken-branch pulse and target
//   master = fetch stage side, slave = environment (memory, decode, branch unit) side
interface instr_fetch_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    import instr_fetch_pkg::*;

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic [GROUP_W-1:0]     command_group;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, command_group,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, command_group,
        output instr_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_skid_buf.sv
// instr_fetch_skid_buf: one-entry instruction+PC holding register
//   in_valid/in_ready/in_instr/in_pc    : load side (in_ready = empty)
//   out_valid/out_ready/out_instr/out_pc : drain side (out_ready empties the entry)
//   flush                                : drop the entry, wins over a load
module instr_fetch_skid_buf #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc
);
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;

    always_comb begin
        valid_d = flush ? 1'b0 : in_valid ? 1'b1 : out_ready ? 1'b0 : valid_q;
        instr_d = in_valid ? in_instr : instr_q;
        pc_d    = in_valid ? in_pc : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign in_ready  = ~valid_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage owning the PC, reading instruction memory and feeding decode
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_if.master carrying imem req/gnt/rvalid, the instr valid/ready
//                stream (instr, instr_pc, command_group) and the redirect pulse
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter int                  GROUP_MSB   = DEFAULT_GROUP_MSB,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                   out_valid_q, out_valid_d;
    logic                   drop_q, drop_d;
    logic                   started_q;

    logic                   skid_empty, skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    logic redirect, consume, gnt_fire, rsp, rsp_keep, load_out, load_skid, skid_pop;

    assign redirect  = bus.redirect_valid;
    assign consume   = out_valid_q & bus.instr_ready;
    assign gnt_fire  = bus.imem_req & bus.imem_gnt;
    assign rsp       = (state_q == S_WAIT) & bus.imem_rvalid;
    // A response is kept only if it is on the correct path: not marked for drop
    // by an earlier redirect and not killed by a redirect in this very cycle.
    assign rsp_keep  = rsp & ~drop_q & ~redirect;
    assign load_out  = rsp_keep & (~out_valid_q | consume);
    assign load_skid = rsp_keep & ~load_out;
    // No request is issued while the skid holds data, so a skid drain and a
    // memory response never compete for the output register.
    assign skid_pop  = consume & skid_valid & ~redirect;

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        req_pc_d = req_pc_q;
        pc_d     = redirect ? bus.redirect_pc : gnt_fire ? pc_q + PC_WIDTH'(1) : pc_q;
        if (state_q == S_REQ) begin
            if (gnt_fire) begin
                state_d  = S_WAIT;
                req_pc_d = pc_q;
                drop_d   = redirect;
            end
        end else if (bus.imem_rvalid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
        end else if (redirect) begin
            drop_d = 1'b1;
        end
        out_valid_d = redirect ? 1'b0 : (load_out | skid_pop) ? 1'b1 : consume ? 1'b0 : out_valid_q;
        out_instr_d = load_out ? bus.imem_rdata : skid_pop ? skid_instr : out_instr_q;
        out_pc_d    = load_out ? req_pc_q : skid_pop ? skid_pc : out_pc_q;
    end

    // started_q holds the request low during reset and lets the first request
    // appear in the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            drop_q      <= 1'b0;
            started_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            drop_q      <= drop_d;
            started_q   <= 1'b1;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    instr_fetch_skid_buf #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .in_valid  (load_skid),
        .in_ready  (skid_empty),
        .in_instr  (bus.imem_rdata),
        .in_pc     (req_pc_q),
        .out_valid (skid_valid),
        .out_ready (consume),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    assign bus.imem_req      = started_q & (state_q == S_REQ) & skid_empty;
    assign bus.imem_addr     = pc_q;
    assign bus.instr_valid   = out_valid_q;
    assign bus.instr         = out_instr_q;
    assign bus.instr_pc      = out_pc_q;
    assign bus.command_group = out_instr_q[GROUP_MSB -: GROUP_W];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against a stream-level reference model
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();
    instr_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    int   gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    logic redir_v = 1'b0;
    logic [7:0] redir_pc = 8'h00;
    bit   mem_hold = 1'b0;

    bit         pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] pend_addr = 8'h00;

    // Reference model: the consumed stream must be the contiguous PC sequence
    // restarting at every redirect target; granted addresses likewise.
    logic [7:0]  exp_pc = 8'h00, exp_req = 8'h00;
    bit          outs = 1'b0;
    int          viol_multi = 0, viol_stab = 0;
    logic [7:0]  cons_exp[$], cons_pc[$], gr_addr[$], gr_exp[$];
    logic [15:0] cons_instr[$];
    logic [2:0]  cons_grp[$];

    bit          p_hold = 1'b0;
    logic [15:0] p_instr;
    logic [7:0]  p_pc;
    logic [2:0]  p_grp;

    function automatic logic [15:0] mem_word(logic [7:0] a);
        return 16'(a) * 16'h0101;
    endfunction

    task automatic clear_q();
        cons_exp.delete(); cons_pc.delete(); cons_instr.delete(); cons_grp.delete();
        gr_addr.delete(); gr_exp.delete();
    endtask

    // One clock: sample outputs at the negedge, drive inputs, take the posedge,
    // update memory and reference model, return at the next negedge.
    task automatic tick();
        logic s_req, s_val, s_rdy, s_gnt, s_rv, s_redir;
        logic [7:0] s_addr, s_pc, s_rpc;
        logic [15:0] s_instr;
        logic [2:0] s_grp;
        s_req = bus.imem_req; s_addr = bus.imem_addr; s_val = bus.instr_valid;
        s_instr = bus.instr; s_pc = bus.instr_pc; s_grp = bus.command_group;
        if (rst_n && p_hold && !(s_val === 1'b1 && s_instr === p_instr && s_pc === p_pc && s_grp === p_grp)) viol_stab++;
        if (rst_n && s_req === 1'b1 && outs) viol_multi++;
        s_gnt = rst_n && s_req === 1'b1 && !pend && ($urandom_range(0, 99) < gnt_pct);
        s_rv = pend && !mem_hold && pend_cnt <= 1;
        s_rdy = $urandom_range(0, 99) < rdy_pct;
        s_redir = redir_v; s_rpc = redir_pc;
        bus.imem_gnt = s_gnt;
        bus.imem_rvalid = s_rv;
        bus.imem_rdata = s_rv ? mem_word(pend_addr) : 16'($urandom);
        bus.instr_ready = s_rdy;
        bus.redirect_valid = s_redir;
        bus.redirect_pc = s_rpc;
        @(posedge clk);
        if (pend && !mem_hold) begin
            if (s_rv) pend = 1'b0;
            else pend_cnt--;
        end
        if (s_rv) outs = 1'b0;
        if (!rst_n) begin
            exp_pc = 8'h00; exp_req = 8'h00; outs = 1'b0; p_hold = 1'b0;
        end else begin
            if (s_gnt) begin
                gr_addr.push_back(s_addr); gr_exp.push_back(exp_req); exp_req++;
                outs = 1'b1; pend = 1'b1; pend_cnt = $urandom_range(lat_min, lat_max); pend_addr = s_addr;
            end
            if (s_val === 1'b1 && s_rdy) begin
                cons_exp.push_back(exp_pc); cons_pc.push_back(s_pc);
                cons_instr.push_back(s_instr); cons_grp.push_back(s_grp); exp_pc++;
            end
            if (s_redir) begin
                exp_pc = s_rpc; exp_req = s_rpc;
            end
            p_hold = s_val === 1'b1 && !s_rdy && !s_redir;
            p_instr = s_instr; p_pc = s_pc; p_grp = s_grp;
        end
        redir_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", bus.instr); else n_pass++;
        n_checks++; if (bus.instr_pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", bus.instr_pc); else n_pass++;
        n_checks++; if (bus.command_group !== 3'd0) $display("FAIL reset_group: got %0d want 0", bus.command_group); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00)
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00", bus.imem_req, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        int k = 0;
        logic [15:0] w;
        while (k < 40 && cons_pc.size() < 4) begin tick(); k++; end
        n_checks++;
        if (cons_pc.size() < 4) begin $display("FAIL seq_timeout: got %0d instrs want 4", cons_pc.size()); return; end
        n_pass++;
        n_checks++; if (gr_addr[0] !== 8'h00) $display("FAIL seq_first_addr: got %h want 00", gr_addr[0]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            w = mem_word(8'(i));
            n_checks++; if (cons_pc[i] !== 8'(i)) $display("FAIL seq_pc[%0d]: got %h want %h", i, cons_pc[i], 8'(i)); else n_pass++;
            n_checks++; if (cons_instr[i] !== w) $display("FAIL seq_instr[%0d]: got %h want %h", i, cons_instr[i], w); else n_pass++;
            n_checks++; if (cons_grp[i] !== w[15:13]) $display("FAIL seq_group[%0d]: got %0d want %0d", i, cons_grp[i], w[15:13]); else n_pass++;
        end
    endtask

    task automatic test_stall();
        int k = 0;
        logic [7:0] sp;
        while (k < 20 && bus.instr_valid !== 1'b1) begin tick(); k++; end
        n_checks++;
        if (bus.instr_valid !== 1'b1) begin $display("FAIL stall_timeout: got valid=%b want 1", bus.instr_valid); return; end
        n_pass++;
        sp = bus.instr_pc;
        rdy_pct = 0;
        repeat (5) begin
            tick();
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(sp) || bus.instr_pc !== sp)
                $display("FAIL stall_hold: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", bus.instr_valid, bus.instr, bus.instr_pc, mem_word(sp), sp);
            else n_pass++;
        end
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req_off: got %b want 0", bus.imem_req); else n_pass++;
        clear_q();
        rdy_pct = 100;
        tick();
        n_checks++;
        if (cons_pc.size() != 1 || cons_pc[0] !== sp) $display("FAIL stall_release_consume: got n=%0d want pc %h consumed", cons_pc.size(), sp);
        else n_pass++;
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== sp + 8'd1 || bus.instr !== mem_word(sp + 8'd1))
            $display("FAIL stall_skid_out: got v=%b pc=%h instr=%h want v=1 pc=%h", bus.instr_valid, bus.instr_pc, bus.instr, sp + 8'd1);
        else n_pass++;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== sp + 8'd2)
            $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, sp + 8'd2);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        int k = 0;
        lat_min = 2; lat_max = 2;
        clear_q();
        while (k < 20 && gr_addr.size() == 0) begin tick(); k++; end
        n_checks++;
        if (gr_addr.size() == 0) begin $display("FAIL rw_timeout: got no grant want one"); return; end
        n_pass++;
        redir_v = 1'b1; redir_pc = 8'h40;
        tick();
        lat_min = 1; lat_max = 1;
        clear_q();
        k = 0;
        while (k < 30 && cons_pc.size() == 0) begin tick(); k++; end
        n_checks++;
        if (cons_pc.size() == 0 || gr_addr.size() == 0) begin $display("FAIL rw_timeout2: got %0d instrs want 1", cons_pc.size()); return; end
        n_pass++;
        n_checks++; if (gr_addr[0] !== 8'h40) $display("FAIL rw_addr: got %h want 40", gr_addr[0]); else n_pass++;
        n_checks++; if (cons_pc[0] !== 8'h40) $display("FAIL rw_pc: got %h want 40", cons_pc[0]); else n_pass++;
        n_checks++; if (cons_instr[0] !== 16'h4040) $display("FAIL rw_instr: got %h want 4040", cons_instr[0]); else n_pass++;
    endtask

    task automatic test_redirect_gnt();
        int k = 0;
        while (k < 20 && bus.imem_req !== 1'b1) begin tick(); k++; end
        clear_q();
        redir_v = 1'b1; redir_pc = 8'h10;
        tick();
        n_checks++; if (gr_addr.size() != 1) $display("FAIL rg_same_cycle_gnt: got %0d grants want 1", gr_addr.size()); else n_pass++;
        clear_q();
        k = 0;
        while (k < 40 && (gr_addr.size() < 2 || cons_pc.size() < 2)) begin tick(); k++; end
        n_checks++;
        if (gr_addr.size() < 2 || cons_pc.size() < 2) begin $display("FAIL rg_timeout: got %0d grants %0d instrs want 2/2", gr_addr.size(), cons_pc.size()); return; end
        n_pass++;
        n_checks++; if (gr_addr[0] !== 8'h10) $display("FAIL rg_addr0: got %h want 10", gr_addr[0]); else n_pass++;
        n_checks++; if (gr_addr[1] !== 8'h11) $display("FAIL rg_addr1: got %h want 11", gr_addr[1]); else n_pass++;
        n_checks++; if (cons_pc[0] !== 8'h10) $display("FAIL rg_pc0: got %h want 10", cons_pc[0]); else n_pass++;
        n_checks++; if (cons_instr[0] !== 16'h1010) $display("FAIL rg_instr0: got %h want 1010", cons_instr[0]); else n_pass++;
        n_checks++; if (cons_pc[1] !== 8'h11) $display("FAIL rg_pc1: got %h want 11", cons_pc[1]); else n_pass++;
    endtask

    task automatic test_wrap();
        int k = 0;
        logic [7:0] e;
        redir_v = 1'b1; redir_pc = 8'hFE;
        tick();
        clear_q();
        while (k < 60 && (gr_addr.size() < 3 || cons_pc.size() < 3)) begin tick(); k++; end
        n_checks++;
        if (gr_addr.size() < 3 || cons_pc.size() < 3) begin $display("FAIL wrap_timeout: got %0d grants %0d instrs want 3/3", gr_addr.size(), cons_pc.size()); return; end
        n_pass++;
        for (int i = 0; i < 3; i++) begin
            e = 8'hFE + 8'(i);
            n_checks++; if (gr_addr[i] !== e) $display("FAIL wrap_addr[%0d]: got %h want %h", i, gr_addr[i], e); else n_pass++;
            n_checks++; if (cons_pc[i] !== e || cons_instr[i] !== mem_word(e)) $display("FAIL wrap_instr[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, cons_pc[i], cons_instr[i], e, mem_word(e)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        lat_min = 3; lat_max = 3;
        clear_q();
        while (k < 20 && gr_addr.size() == 0) begin tick(); k++; end
        n_checks++;
        if (gr_addr.size() == 0) begin $display("FAIL rm_timeout: got no grant want one"); return; end
        n_pass++;
        mem_hold = 1'b1;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00 || bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 8'h00 || bus.command_group !== 3'd0)
            $display("FAIL rm_in_reset: got req=%b addr=%h v=%b instr=%h pc=%h grp=%0d want all zero", bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.command_group);
        else n_pass++;
        tick();
        pend_cnt = 1; gnt_pct = 0; mem_hold = 1'b0;
        lat_min = 1; lat_max = 1;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rm_stale_ignored: got valid=%b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); else n_pass++;
        gnt_pct = 100;
        clear_q();
        k = 0;
        while (k < 30 && cons_pc.size() == 0) begin tick(); k++; end
        n_checks++;
        if (cons_pc.size() == 0 || gr_addr.size() == 0) begin $display("FAIL rm_timeout2: got %0d instrs want 1", cons_pc.size()); return; end
        n_pass++;
        n_checks++; if (gr_addr[0] !== 8'h00) $display("FAIL rm_first_addr: got %h want 00", gr_addr[0]); else n_pass++;
        n_checks++; if (cons_pc[0] !== 8'h00 || cons_instr[0] !== 16'h0000) $display("FAIL rm_first_instr: got pc=%h instr=%h want 00/0000", cons_pc[0], cons_instr[0]); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] w;
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3;
        clear_q();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin redir_v = 1'b1; redir_pc = 8'($urandom); end
            tick();
        end
        n_checks++; if (cons_pc.size() < 100) $display("FAIL rnd_throughput: got %0d instrs want >=100", cons_pc.size()); else n_pass++;
        foreach (cons_pc[i]) begin
            w = mem_word(cons_exp[i]);
            n_checks++;
            if (cons_pc[i] !== cons_exp[i] || cons_instr[i] !== w || cons_grp[i] !== w[15:13])
                $display("FAIL rnd_instr[%0d]: got pc=%h instr=%h grp=%0d want pc=%h instr=%h grp=%0d", i, cons_pc[i], cons_instr[i], cons_grp[i], cons_exp[i], w, w[15:13]);
            else n_pass++;
        end
        foreach (gr_addr[i]) begin
            n_checks++; if (gr_addr[i] !== gr_exp[i]) $display("FAIL rnd_addr[%0d]: got %h want %h", i, gr_addr[i], gr_exp[i]); else n_pass++;
        end
        n_checks++; if (viol_multi != 0) $display("FAIL one_outstanding: got %0d overlaps want 0", viol_multi); else n_pass++;
        n_checks++; if (viol_stab != 0) $display("FAIL hold_stable: got %0d changes want 0", viol_stab); else n_pass++;
    endtask

    initial begin
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 16'h0000;
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
